// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI transfer sequencer.
//   - Wishbone register addresses of the simple_spi_top core
//   - fixed register values (SPCR base bits, abort value, SPIF clear)
//   - sequencer FSM state encoding
package spi_seq_pkg;

    localparam logic [1:0] ADR_SPCR = 2'd0;
    localparam logic [1:0] ADR_SPSR = 2'd1;
    localparam logic [1:0] ADR_SPDR = 2'd2;
    localparam logic [1:0] ADR_SPER = 2'd3;

    // SPIE=0, SPE=1, reserved=0, MSTR=1 above {cpol, cpha, spr[1:0]}
    localparam logic [3:0] SPCR_BASE  = 4'b0101;
    // SPE=0 disables the core, which flushes its FIFOs after a stuck transfer
    localparam logic [7:0] SPCR_ABORT = 8'h10;
    localparam logic [7:0] SPER_VALUE = 8'h00;
    // Writing a one to SPIF clears it
    localparam logic [7:0] SPSR_CLEAR = 8'h80;
    localparam int         SPIF_BIT   = 7;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARB,
        ST_WR_SPCR,
        ST_WR_SPER,
        ST_WR_SPDR,
        ST_RD_SPSR,
        ST_WR_SPSR,
        ST_RD_SPDR,
        ST_ABORT,
        ST_RESP
    } state_t;

    function automatic logic [7:0] spcr_value(input logic [3:0] cfg);
        return {SPCR_BASE, cfg};
    endfunction

endpackage

// File: rtl/spi_seq_rr_arb.sv
// Round-robin arbiter for the SPI transfer sequencer.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : per-requester request vector
//   accept      : the current grant is taken; advances the pointer past it
//   grant       : one-hot grant (first request at or after the pointer)
//   grant_id    : binary index of the granted requester
//   any         : at least one request is present
module spi_seq_rr_arb #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            accept,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            any
);

    logic [IDW-1:0] ptr_reg;
    logic [IDW-1:0] ptr_next;

    always_comb begin
        int idx;
        idx      = 0;
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        // Scan NREQ positions starting at the pointer, wrapping once
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_reg) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant_id   = IDW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (accept && any) begin
            ptr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Wishbone master that runs byte transfers on simple_spi_top for NREQ
// requesters. Each granted request reprograms SPCR/SPER only when its mode
// differs from the cached one, writes SPDR, polls SPSR for SPIF, clears SPIF,
// reads SPDR and returns the received byte. A poll timeout disables the core
// and answers with err=1, data=0.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-low reset
//   req_valid_i/ready_o : per-requester handshake (ready is a one-hot pulse)
//   req_cfg_i           : requester i at [4i+3:4i] = {cpol, cpha, spr[1:0]}
//   req_data_i          : requester i tx byte at [8i+7:8i]
//   rsp_*               : response handshake with id, rx byte and error flag
//   adr_o..ack_i        : wishbone master port to the SPI core
module spi_xfer_sequencer
    import spi_seq_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int POLL_MAX = 1024,
    parameter int IDW      = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [4*NREQ-1:0] req_cfg_i,
    input  logic [8*NREQ-1:0] req_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [IDW-1:0]    rsp_id_o,
    output logic [7:0]        rsp_data_o,
    output logic              rsp_err_o,
    output logic [1:0]        adr_o,
    output logic [7:0]        dat_o,
    input  logic [7:0]        dat_i,
    output logic              we_o,
    output logic              cyc_o,
    output logic              stb_o,
    input  logic              ack_i
);

    // Holds POLL_MAX itself, so the count never wraps
    localparam int PCW = $clog2(POLL_MAX + 1);

    state_t         state_reg, state_next;
    logic [3:0]     cfg_reg, cfg_next;
    logic [7:0]     tx_reg, tx_next;
    logic [IDW-1:0] id_reg, id_next;
    logic [7:0]     rx_reg, rx_next;
    logic           err_reg, err_next;
    logic [3:0]     cache_cfg_reg, cache_cfg_next;
    logic           cache_valid_reg, cache_valid_next;
    logic [PCW-1:0] poll_reg, poll_next;
    logic           cyc_reg, cyc_next;
    logic           we_reg, we_next;
    logic [1:0]     adr_reg, adr_next;
    logic [7:0]     dat_reg, dat_next;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            grant_any;
    logic            accept;

    spi_seq_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .req      (req_valid_i),
        .accept   (accept),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (grant_any)
    );

    // Mux the granted requester's cfg/data via one-hot masking
    logic [3:0] cfg_masked  [NREQ];
    logic [7:0] data_masked [NREQ];
    logic [3:0] sel_cfg;
    logic [7:0] sel_data;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_sel
            assign cfg_masked[gi]  = req_cfg_i[4*gi +: 4]  & {4{grant[gi]}};
            assign data_masked[gi] = req_data_i[8*gi +: 8] & {8{grant[gi]}};
        end
    endgenerate

    always_comb begin
        sel_cfg  = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_cfg  = sel_cfg | cfg_masked[i];
            sel_data = sel_data | data_masked[i];
        end
    end

    // Bus access implied by the current state
    logic       is_bus;
    logic       acc_we;
    logic [1:0] acc_adr;
    logic [7:0] acc_dat;

    always_comb begin
        is_bus  = 1'b1;
        acc_we  = 1'b1;
        acc_adr = ADR_SPCR;
        acc_dat = '0;
        case (state_reg)
            ST_WR_SPCR: acc_dat = spcr_value(cfg_reg);
            ST_WR_SPER: begin acc_adr = ADR_SPER; acc_dat = SPER_VALUE; end
            ST_WR_SPDR: begin acc_adr = ADR_SPDR; acc_dat = tx_reg; end
            ST_RD_SPSR: begin acc_adr = ADR_SPSR; acc_we = 1'b0; end
            ST_WR_SPSR: begin acc_adr = ADR_SPSR; acc_dat = SPSR_CLEAR; end
            ST_RD_SPDR: begin acc_adr = ADR_SPDR; acc_we = 1'b0; end
            ST_ABORT:   acc_dat = SPCR_ABORT;
            default:    is_bus = 1'b0;
        endcase
    end

    logic done;
    assign done = cyc_reg && ack_i;

    always_comb begin
        state_next       = state_reg;
        cfg_next         = cfg_reg;
        tx_next          = tx_reg;
        id_next          = id_reg;
        rx_next          = rx_reg;
        err_next         = err_reg;
        cache_cfg_next   = cache_cfg_reg;
        cache_valid_next = cache_valid_reg;
        poll_next        = poll_reg;
        cyc_next         = cyc_reg;
        we_next          = we_reg;
        adr_next         = adr_reg;
        dat_next         = dat_reg;
        accept           = 1'b0;

        // A bus state launches its access from an idle bus; after the ack the
        // bus drops for a cycle, which also separates repeated SPSR reads.
        if (is_bus && !cyc_reg) begin
            cyc_next = 1'b1;
            we_next  = acc_we;
            adr_next = acc_adr;
            dat_next = acc_dat;
        end
        if (done) begin
            cyc_next = 1'b0;
            we_next  = 1'b0;
            adr_next = '0;
            dat_next = '0;
        end

        case (state_reg)
            ST_IDLE: begin
                if (|req_valid_i) begin
                    state_next = ST_ARB;
                end
            end
            ST_ARB: begin
                if (grant_any) begin
                    accept   = 1'b1;
                    cfg_next = sel_cfg;
                    tx_next  = sel_data;
                    id_next  = grant_id;
                    rx_next  = '0;
                    err_next = 1'b0;
                    if (!cache_valid_reg || sel_cfg != cache_cfg_reg) begin
                        state_next = ST_WR_SPCR;
                    end else begin
                        state_next = ST_WR_SPDR;
                        poll_next  = '0;
                    end
                end else begin
                    // Requester withdrew before grant
                    state_next = ST_IDLE;
                end
            end
            ST_WR_SPCR: begin
                if (done) state_next = ST_WR_SPER;
            end
            ST_WR_SPER: begin
                if (done) begin
                    cache_cfg_next   = cfg_reg;
                    cache_valid_next = 1'b1;
                    poll_next        = '0;
                    state_next       = ST_WR_SPDR;
                end
            end
            ST_WR_SPDR: begin
                if (done) state_next = ST_RD_SPSR;
            end
            ST_RD_SPSR: begin
                if (done) begin
                    poll_next = poll_reg + 1'b1;
                    if (dat_i[SPIF_BIT]) begin
                        state_next = ST_WR_SPSR;
                    end else if (poll_reg == PCW'(POLL_MAX - 1)) begin
                        state_next = ST_ABORT;
                    end
                end
            end
            ST_WR_SPSR: begin
                if (done) state_next = ST_RD_SPDR;
            end
            ST_RD_SPDR: begin
                if (done) begin
                    rx_next    = dat_i;
                    state_next = ST_RESP;
                end
            end
            ST_ABORT: begin
                if (done) begin
                    cache_valid_next = 1'b0;
                    err_next         = 1'b1;
                    rx_next          = '0;
                    state_next       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg       <= ST_IDLE;
            cfg_reg         <= '0;
            tx_reg          <= '0;
            id_reg          <= '0;
            rx_reg          <= '0;
            err_reg         <= 1'b0;
            cache_cfg_reg   <= '0;
            cache_valid_reg <= 1'b0;
            poll_reg        <= '0;
            cyc_reg         <= 1'b0;
            we_reg          <= 1'b0;
            adr_reg         <= '0;
            dat_reg         <= '0;
        end else begin
            state_reg       <= state_next;
            cfg_reg         <= cfg_next;
            tx_reg          <= tx_next;
            id_reg          <= id_next;
            rx_reg          <= rx_next;
            err_reg         <= err_next;
            cache_cfg_reg   <= cache_cfg_next;
            cache_valid_reg <= cache_valid_next;
            poll_reg        <= poll_next;
            cyc_reg         <= cyc_next;
            we_reg          <= we_next;
            adr_reg         <= adr_next;
            dat_reg         <= dat_next;
        end
    end

    assign req_ready_o = accept ? grant : '0;
    assign rsp_valid_o = (state_reg == ST_RESP);
    assign rsp_id_o    = id_reg;
    assign rsp_data_o  = rx_reg;
    assign rsp_err_o   = err_reg;
    assign cyc_o       = cyc_reg;
    assign stb_o       = cyc_reg;
    assign we_o        = we_reg;
    assign adr_o       = adr_reg;
    assign dat_o       = dat_reg;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Scoreboard bench for spi_xfer_sequencer. A behavioural SPI-core slave
// answers the wishbone port (random ack latency, SPIF after k polls, SPDR
// echoing the previously written byte). At each grant a reference model
// derives the expected bus operations and response from the register rules.
module tb_spi_xfer_sequencer;

    localparam int NREQ     = 3;
    localparam int IDW      = 2;
    localparam int POLL_MAX = 4;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic [NREQ-1:0]     req_valid_i;
    logic [NREQ-1:0]     req_ready_o;
    logic [4*NREQ-1:0]   req_cfg_i;
    logic [8*NREQ-1:0]   req_data_i;
    logic                rsp_valid_o;
    logic                rsp_ready_i;
    logic [IDW-1:0]      rsp_id_o;
    logic [7:0]          rsp_data_o;
    logic                rsp_err_o;
    logic [1:0]          adr_o;
    logic [7:0]          dat_o;
    logic [7:0]          dat_i;
    logic                we_o;
    logic                cyc_o;
    logic                stb_o;
    logic                ack_i;

    always #5 clk_i = ~clk_i;

    spi_xfer_sequencer #(
        .NREQ     (NREQ),
        .POLL_MAX (POLL_MAX),
        .IDW      (IDW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_cfg_i   (req_cfg_i),
        .req_data_i  (req_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_id_o    (rsp_id_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o),
        .adr_o       (adr_o),
        .dat_o       (dat_o),
        .dat_i       (dat_i),
        .we_o        (we_o),
        .cyc_o       (cyc_o),
        .stb_o       (stb_o),
        .ack_i       (ack_i)
    );

    typedef struct packed { logic [3:0] cfg; logic [7:0] tx; } req_t;
    typedef struct packed { logic we; logic [1:0] adr; logic [7:0] dat; } op_t;
    typedef struct packed { logic [IDW-1:0] id; logic [7:0] data; logic err; } rsp_t;

    req_t rq_q [NREQ][$];
    op_t  exp_ops[$];
    rsp_t exp_rsp[$];

    int checks = 0;
    int errors = 0;

    // reference model state
    int         mdl_ptr = 0;
    bit         mdl_cache_valid = 0;
    logic [3:0] mdl_cache_cfg = '0;
    logic [7:0] mdl_prev = 8'h00;

    // slave state
    int         slv_k = 1;
    bit         slv_stuck = 0;
    logic [7:0] slv_prev = 8'h00;
    logic [7:0] slv_rx = 8'h00;
    int         slv_reads = 0;

    // stimulus controls
    bit force_on = 0;
    int force_k = 1;
    bit force_stuck = 0;
    bit rdy_hold_low = 0;
    bit use_gap = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic bit busy();
        bit b;
        b = (exp_rsp.size() != 0) || (exp_ops.size() != 0);
        for (int i = 0; i < NREQ; i++) begin
            if (rq_q[i].size() != 0) b = 1;
        end
        return b;
    endfunction

    task automatic push_req(input int id, input logic [3:0] cfg, input logic [7:0] tx);
        req_t r;
        r.cfg = cfg;
        r.tx  = tx;
        rq_q[id].push_back(r);
    endtask

    task automatic drain(input int maxc);
        int c;
        c = 0;
        while (busy() && c < maxc) begin
            @(posedge clk_i);
            c++;
        end
        chk("drain_done", 32'(busy()), 32'(0));
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    // Reference model: runs when the DUT pulses req_ready_o
    task automatic model_grant();
        int              g;
        int              c;
        int              n;
        logic [NREQ-1:0] ev;
        req_t            r;
        op_t             op;
        rsp_t            rs;
        bit              stuck;
        int              k;
        g  = -1;
        ev = '0;
        for (int j = 0; j < NREQ; j++) begin
            c = (mdl_ptr + j) % NREQ;
            if (g < 0 && req_valid_i[c]) g = c;
        end
        if (g >= 0) ev[g] = 1'b1;
        chk("grant", 32'(req_ready_o), 32'(ev));
        if (g < 0 || rq_q[g].size() == 0) return;
        r = rq_q[g][0];
        mdl_ptr = (g + 1) % NREQ;
        if (force_on) begin
            k = force_k; stuck = force_stuck; force_on = 0;
        end else begin
            stuck = ($urandom_range(0, 5) == 0);
            k = int'($urandom_range(1, POLL_MAX));
        end
        slv_k = k;
        slv_stuck = stuck;
        if (!mdl_cache_valid || r.cfg != mdl_cache_cfg) begin
            op = '{1'b1, 2'd0, {4'b0101, r.cfg}}; exp_ops.push_back(op);
            op = '{1'b1, 2'd3, 8'h00};            exp_ops.push_back(op);
            mdl_cache_valid = 1;
            mdl_cache_cfg = r.cfg;
        end
        op = '{1'b1, 2'd2, r.tx}; exp_ops.push_back(op);
        n = stuck ? POLL_MAX : k;
        for (int j = 0; j < n; j++) begin
            op = '{1'b0, 2'd1, 8'h00}; exp_ops.push_back(op);
        end
        rs.id = IDW'(g);
        if (stuck) begin
            op = '{1'b1, 2'd0, 8'h10}; exp_ops.push_back(op);
            mdl_cache_valid = 0;
            rs.data = 8'h00; rs.err = 1'b1;
        end else begin
            op = '{1'b1, 2'd1, 8'h80}; exp_ops.push_back(op);
            op = '{1'b0, 2'd2, 8'h00}; exp_ops.push_back(op);
            rs.data = mdl_prev; rs.err = 1'b0;
        end
        exp_rsp.push_back(rs);
        mdl_prev = r.tx;
    endtask

    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i && req_ready_o != '0) model_grant();
        end
    end

    // Requester drivers
    initial begin
        bit acc   [NREQ];
        int gap   [NREQ];
        int waitc [NREQ];
        req_valid_i = '0;
        req_cfg_i   = '0;
        req_data_i  = '0;
        for (int i = 0; i < NREQ; i++) begin
            acc[i] = 0; gap[i] = 0; waitc[i] = 0;
        end
        forever begin
            @(negedge clk_i);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid_i[i] && req_ready_o[i]) acc[i] = 1;
            end
            @(posedge clk_i);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    req_valid_i[i] = 1'b0;
                    void'(rq_q[i].pop_front());
                    acc[i] = 0;
                    waitc[i] = 0;
                    gap[i] = use_gap ? int'($urandom_range(0, 6)) : 0;
                end else if (req_valid_i[i]) begin
                    waitc[i]++;
                    if (waitc[i] > 3000) begin
                        checks++; errors++;
                        $display("FAIL req_wait id=%0d got=no_ready exp=ready", i);
                        req_valid_i[i] = 1'b0;
                        void'(rq_q[i].pop_front());
                        waitc[i] = 0;
                    end
                end else if (rq_q[i].size() != 0 && rst_i) begin
                    if (gap[i] > 0) begin
                        gap[i]--;
                    end else begin
                        req_valid_i[i] = 1'b1;
                        req_cfg_i[4*i +: 4]  = rq_q[i][0].cfg;
                        req_data_i[8*i +: 8] = rq_q[i][0].tx;
                    end
                end
            end
        end
    end

    // SPI core slave model; also checks each acknowledged access
    task automatic slave_access();
        op_t e;
        checks++;
        if (exp_ops.size() == 0) begin
            errors++;
            $display("FAIL bus_unexpected got=we%0d adr%0d dat%h exp=none", we_o, adr_o, dat_o);
        end else begin
            e = exp_ops.pop_front();
            if (e.we !== we_o || e.adr !== adr_o || (e.we && e.dat !== dat_o)) begin
                errors++;
                $display("FAIL bus_op got=we%0d adr%0d dat%h exp=we%0d adr%0d dat%h",
                         we_o, adr_o, dat_o, e.we, e.adr, e.dat);
            end
        end
        dat_i = 8'h00;
        if (we_o) begin
            if (adr_o == 2'd2) begin
                slv_rx = slv_prev;
                slv_prev = dat_o;
                slv_reads = 0;
            end
        end else if (adr_o == 2'd1) begin
            slv_reads++;
            dat_i = (!slv_stuck && slv_reads >= slv_k) ? 8'h80 : 8'h00;
        end else if (adr_o == 2'd2) begin
            dat_i = slv_rx;
        end
    endtask

    initial begin
        bit pend;
        int wcnt;
        pend = 0; wcnt = 0;
        ack_i = 1'b0;
        dat_i = 8'h00;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                ack_i = 1'b0;
                pend = 0;
            end else if (ack_i) begin
                ack_i = 1'b0;
                chk("cyc_drop_after_ack", 32'({cyc_o, stb_o}), 32'(0));
            end else if (cyc_o && stb_o) begin
                if (!pend) begin
                    pend = 1;
                    wcnt = int'($urandom_range(0, 3));
                end
                if (wcnt == 0) begin
                    slave_access();
                    ack_i = 1'b1;
                    pend = 0;
                end else begin
                    wcnt--;
                end
            end
        end
    end

    // Response consumer
    initial begin
        rsp_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            rsp_ready_i = rdy_hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Response monitor
    initial begin
        bit   held;
        rsp_t held_val;
        rsp_t got;
        rsp_t e;
        held = 0;
        held_val = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                held = 0;
            end else if (rsp_valid_o) begin
                got = '{rsp_id_o, rsp_data_o, rsp_err_o};
                chk("no_grant_in_resp", 32'(req_ready_o), 32'(0));
                if (held) chk("rsp_stable", 32'(got), 32'(held_val));
                if (rsp_ready_i) begin
                    held = 0;
                    if (exp_rsp.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rsp_unexpected got=%h exp=none", got);
                    end else begin
                        e = exp_rsp.pop_front();
                        chk("rsp_id", 32'(rsp_id_o), 32'(e.id));
                        chk("rsp_data", 32'(rsp_data_o), 32'(e.data));
                        chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
                    end
                end else begin
                    held = 1;
                    held_val = got;
                end
            end else begin
                held = 0;
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready_o), 32'(0));
        chk({tag, "_rsp"}, 32'({rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o}), 32'(0));
        chk({tag, "_cyc_stb"}, 32'({cyc_o, stb_o}), 32'(0));
        chk({tag, "_we_adr_dat"}, 32'({we_o, adr_o, dat_o}), 32'(0));
    endtask

    initial begin
        int c;
        logic [3:0] cfg_pool [4];
        cfg_pool[0] = 4'b0000; cfg_pool[1] = 4'b1101;
        cfg_pool[2] = 4'b0011; cfg_pool[3] = 4'b0110;
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_outputs_zero("reset");
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;

        // First transfer programs the mode
        force_k = 2; force_stuck = 0; force_on = 1;
        push_req(0, 4'b0000, 8'h3C);
        drain(2000);

        // Same mode: SPDR is the first access
        force_k = 1; force_stuck = 0; force_on = 1;
        push_req(0, 4'b0000, 8'hA5);
        drain(2000);

        // Two requesters continuously valid, alternating modes
        push_req(0, 4'b0000, 8'h11);
        push_req(1, 4'b1101, 8'h22);
        push_req(0, 4'b0000, 8'h33);
        push_req(1, 4'b1101, 8'h44);
        drain(4000);

        // Poll timeout, then the mode must be rewritten
        force_stuck = 1; force_k = 1; force_on = 1;
        push_req(1, 4'b1101, 8'h55);
        drain(2000);
        push_req(1, 4'b1101, 8'h66);
        drain(2000);

        // SPIF on the last allowed poll still succeeds
        force_k = POLL_MAX; force_stuck = 0; force_on = 1;
        push_req(2, 4'b0011, 8'h77);
        drain(2000);

        // Response back-pressure with another request waiting
        rdy_hold_low = 1;
        push_req(0, 4'b0110, 8'h88);
        c = 0;
        while (!rsp_valid_o && c < 2000) begin
            @(posedge clk_i); #1; c++;
        end
        chk("rsp_valid_seen", 32'(rsp_valid_o), 32'(1));
        push_req(1, 4'b0110, 8'h9A);
        repeat (20) @(posedge clk_i);
        #1;
        chk("rsp_still_valid", 32'(rsp_valid_o), 32'(1));
        rdy_hold_low = 0;
        drain(4000);

        // Randomized traffic
        use_gap = 1;
        for (int n = 0; n < 60; n++) begin
            push_req(int'($urandom_range(0, NREQ - 1)), cfg_pool[$urandom_range(0, 3)],
                     8'($urandom_range(0, 255)));
        end
        drain(30000);
        use_gap = 0;

        // Reset during an SPSR poll
        force_stuck = 1; force_k = 1; force_on = 1;
        push_req(0, 4'b0000, 8'h99);
        c = 0;
        while (!(cyc_o && stb_o && !we_o && adr_o == 2'd1) && c < 2000) begin
            @(negedge clk_i); c++;
        end
        chk("spsr_poll_seen", 32'({cyc_o, adr_o}), 32'({1'b1, 2'd1}));
        #1;
        rst_i = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        exp_ops.delete();
        exp_rsp.delete();
        mdl_cache_valid = 0;
        mdl_ptr = 0;
        repeat (3) @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        push_req(0, 4'b0000, 8'hC3);
        drain(2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
